pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that generalises the fixed stage registers between pipeline stages. It carries a generic control/data payload, adds a valid/ready handshake with backpressure, and supports priority-ordered flush and bubble insertion. It also generates per-channel one-shot start pulses for multi-cycle units and counts inserted bubbles. One instance sits at each stage boundary (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 174 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake bundle for pipe_stage_reg.
// The slave modport is the stage's view and the master modport is the
// surrounding logic's view (upstream producer plus downstream consumer).
interface pipe_stage_reg_if #(
  parameter int CTRL_W    = 16,
  parameter int DATA_W    = 128,
  parameter int NUM_START = 2
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [CTRL_W-1:0]    in_ctrl_i;
  logic [DATA_W-1:0]    in_data_i;
  logic [NUM_START-1:0] start_req_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [CTRL_W-1:0]    out_ctrl_o;
  logic [DATA_W-1:0]    out_data_o;
  logic [NUM_START-1:0] start_o;

  modport slave (
    input  in_valid_i, in_ctrl_i, in_data_i, start_req_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, start_o
  );

  modport master (
    output in_valid_i, in_ctrl_i, in_data_i, start_req_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, start_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake,
// priority flush > hold > skid drain > bubble > load, one-shot start pulses
// for multi-cycle units and a saturating bubble counter.
// Optional feature macro: PIPE_SKID_EN adds a 1-entry skid buffer so that
// in_ready_o no longer depends on out_ready_i. The default build has no skid.
module pipe_stage_reg #(
  parameter int CTRL_W    = 16,
  parameter int DATA_W    = 128,
  parameter int NUM_START = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             bubble_i,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] bubble_cnt_o,
  pipe_stage_reg_if.slave  bus
);

  // Saturating increment: an all-ones counter stays all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Main (output) register.
  logic                 r_vld_p1;
  logic [CTRL_W-1:0]    r_ctrl_p1;
  logic [DATA_W-1:0]    r_data_p1;
  logic [NUM_START-1:0] r_start_p1;
  logic [CNT_W-1:0]     r_bub_cnt;

  // Next-state wires.
  logic                 w_adv;
  logic                 w_in_ready;
  logic                 w_vld_nxt;
  logic [CTRL_W-1:0]    w_ctrl_nxt;
  logic [DATA_W-1:0]    w_data_nxt;
  logic [NUM_START-1:0] w_start_nxt;
  logic                 w_bub_inc;

`ifdef PIPE_SKID_EN
  // Skid entry; it only ever holds valid entries, so ctrl/req are stored
  // exactly as accepted.
  logic                 r_skid_vld_p0;
  logic [CTRL_W-1:0]    r_skid_ctrl_p0;
  logic [DATA_W-1:0]    r_skid_data_p0;
  logic [NUM_START-1:0] r_skid_req_p0;

  logic                 w_accept;
  logic                 w_skid_vld_nxt;
  logic [CTRL_W-1:0]    w_skid_ctrl_nxt;
  logic [DATA_W-1:0]    w_skid_data_nxt;
  logic [NUM_START-1:0] w_skid_req_nxt;
`endif

  // Main register may change whenever it is empty or being drained.
  assign w_adv = bus.out_ready_i || !r_vld_p1;

`ifdef PIPE_SKID_EN
  // Readiness is cut from out_ready_i: only the skid occupancy matters.
  assign w_in_ready = !flush_i && !bubble_i && !r_skid_vld_p0;
  assign w_accept   = bus.in_valid_i && w_in_ready;
`else
  assign w_in_ready = !flush_i && !bubble_i && w_adv;
`endif

  // Priority-ordered next state of main (and skid) plus start and bubble events.
  always_comb begin
    w_vld_nxt   = r_vld_p1;
    w_ctrl_nxt  = r_ctrl_p1;
    w_data_nxt  = r_data_p1;
    w_start_nxt = '0;
    w_bub_inc   = 1'b0;
`ifdef PIPE_SKID_EN
    w_skid_vld_nxt  = r_skid_vld_p0;
    w_skid_ctrl_nxt = r_skid_ctrl_p0;
    w_skid_data_nxt = r_skid_data_p0;
    w_skid_req_nxt  = r_skid_req_p0;
`endif
    if (flush_i) begin
      w_vld_nxt  = 1'b0;
      w_ctrl_nxt = '0;
      w_data_nxt = '0;
`ifdef PIPE_SKID_EN
      w_skid_vld_nxt  = 1'b0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_req_nxt  = '0;
`endif
    end else if (!w_adv) begin
      // Hold wins over bubble so the held entry is never lost.
`ifdef PIPE_SKID_EN
      if (w_accept) begin
        w_skid_vld_nxt  = 1'b1;
        w_skid_ctrl_nxt = bus.in_ctrl_i;
        w_skid_data_nxt = bus.in_data_i;
        w_skid_req_nxt  = bus.start_req_i;
      end
`endif
    end
`ifdef PIPE_SKID_EN
    else if (r_skid_vld_p0) begin
      w_vld_nxt       = 1'b1;
      w_ctrl_nxt      = r_skid_ctrl_p0;
      w_data_nxt      = r_skid_data_p0;
      w_start_nxt     = r_skid_req_p0;
      w_skid_vld_nxt  = 1'b0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_req_nxt  = '0;
    end
`endif
    else if (bubble_i) begin
      w_vld_nxt  = 1'b0;
      w_ctrl_nxt = '0;
      w_data_nxt = '0;
      w_bub_inc  = 1'b1;
    end else begin
      w_vld_nxt   = bus.in_valid_i;
      w_ctrl_nxt  = bus.in_valid_i ? bus.in_ctrl_i : '0;
      w_data_nxt  = bus.in_data_i;
      w_start_nxt = bus.in_valid_i ? bus.start_req_i : '0;
    end
  end

  // ---- stage boundary: main register and one-shot start pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_ctrl_p1  <= '0;
      r_data_p1  <= '0;
      r_start_p1 <= '0;
    end else begin
      r_vld_p1   <= w_vld_nxt;
      r_ctrl_p1  <= w_ctrl_nxt;
      r_data_p1  <= w_data_nxt;
      r_start_p1 <= w_start_nxt;
    end
  end

`ifdef PIPE_SKID_EN
  // ---- stage boundary: skid entry captured while downstream holds ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld_p0  <= 1'b0;
      r_skid_ctrl_p0 <= '0;
      r_skid_data_p0 <= '0;
      r_skid_req_p0  <= '0;
    end else begin
      r_skid_vld_p0  <= w_skid_vld_nxt;
      r_skid_ctrl_p0 <= w_skid_ctrl_nxt;
      r_skid_data_p0 <= w_skid_data_nxt;
      r_skid_req_p0  <= w_skid_req_nxt;
    end
  end
`endif

  // Bubble counter: clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_bub_cnt <= '0;
    else if (cnt_clr_i) r_bub_cnt <= '0;
    else if (w_bub_inc) r_bub_cnt <= sat_inc(r_bub_cnt);
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_vld_p1;
  assign bus.out_ctrl_o  = r_ctrl_p1;
  assign bus.out_data_o  = r_data_p1;
  assign bus.start_o     = r_start_p1;
  assign bubble_cnt_o    = r_bub_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors with hand-computed expectations for
// pipe_stage_reg (CTRL_W=16, DATA_W=32, NUM_START=2, CNT_W=4).
module tb_pipe_stage_reg;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 32;
  localparam int NS     = 2;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             bubble_i;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] bubble_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_START(NS)) bus ();

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_START(NS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .bubble_i     (bubble_i),
    .cnt_clr_i    (cnt_clr_i),
    .bubble_cnt_o (bubble_cnt_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [NS-1:0] r);
    bus.in_valid_i  = v;
    bus.in_ctrl_i   = c;
    bus.in_data_i   = d;
    bus.start_req_i = r;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    bubble_i  = 1'b0;
    cnt_clr_i = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    #3;
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("rst_data",  64'(bus.out_data_o),  64'd0);
    check("rst_start", 64'(bus.start_o),     64'd0);
    check("rst_cnt",   64'(bubble_cnt_o),    64'd0);
    #9 rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(bus.in_ready_o), 64'd1);

    // Stream four entries back to back, one-cycle latency.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i * 256), '0);
      tick();
      check("stream_valid", 64'(bus.out_valid_o), 64'd1);
      check("stream_ctrl",  64'(bus.out_ctrl_o),  64'(i));
      check("stream_data",  64'(bus.out_data_o),  64'(i * 256));
    end
    drive(1'b0, 16'h00FF, '0, 2'b11);
    tick();
    check("idle_valid", 64'(bus.out_valid_o), 64'd0);
    check("idle_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("idle_start", 64'(bus.start_o),     64'd0);

    // Hold with bubble requested: nothing changes, nothing counted.
    drive(1'b1, 16'h0005, 32'h55, 2'b01);
    tick();
    check("ld5_start", 64'(bus.start_o), 64'h1);
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b0;
    bubble_i = 1'b1;
    #1;
    check("hold_ready", 64'(bus.in_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(bus.out_valid_o), 64'd1);
      check("hold_ctrl",  64'(bus.out_ctrl_o),  64'h5);
      check("hold_start", 64'(bus.start_o),     64'd0);
      check("hold_cnt",   64'(bubble_cnt_o),    64'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    check("bub_valid", 64'(bus.out_valid_o), 64'd0);
    check("bub_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("bub_cnt",   64'(bubble_cnt_o),    64'd1);
    bubble_i = 1'b0;

    // Start pulse lasts one cycle through a 4-cycle hold.
    drive(1'b1, 16'h0006, 32'h66, 2'b10);
    tick();
    check("st_pulse", 64'(bus.start_o), 64'h2);
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_after", 64'(bus.start_o),    64'd0);
      check("st_ctrl",  64'(bus.out_ctrl_o), 64'h6);
    end

    // Flush during hold wins; counter untouched.
    flush_i = 1'b1;
    tick();
    check("fl_valid", 64'(bus.out_valid_o), 64'd0);
    check("fl_data",  64'(bus.out_data_o),  64'd0);
    check("fl_cnt",   64'(bubble_cnt_o),    64'd1);
    bus.out_ready_i = 1'b1;
    drive(1'b1, 16'h0007, 32'h77, 2'b01);
    #1;
    check("fl_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    check("fl_in_valid", 64'(bus.out_valid_o), 64'd0);
    check("fl_in_start", 64'(bus.start_o),     64'd0);
    flush_i = 1'b0;
    tick();
    check("postfl_ctrl",  64'(bus.out_ctrl_o), 64'h7);
    check("postfl_start", 64'(bus.start_o),    64'h1);

`ifdef PIPE_SKID_EN
    // Hold arrives with an accept: entry parks in skid, then drains in order.
    bus.out_ready_i = 1'b0;
    drive(1'b1, 16'h0008, 32'h88, 2'b10);
    #1;
    check("sk_ready", 64'(bus.in_ready_o), 64'd1);
    tick();
    check("sk_main", 64'(bus.out_ctrl_o), 64'h7);
    check("sk_full", 64'(bus.in_ready_o), 64'd0);
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b1;
    tick();
    check("sk_drain_ctrl",  64'(bus.out_ctrl_o), 64'h8);
    check("sk_drain_start", 64'(bus.start_o),    64'h2);
    tick();
    check("sk_empty", 64'(bus.out_valid_o), 64'd0);
    // Flush with skid full.
    drive(1'b1, 16'h0009, 32'h99, 2'b00);
    tick();
    bus.out_ready_i = 1'b0;
    drive(1'b1, 16'h000A, 32'hAA, 2'b00);
    tick();
    drive(1'b0, '0, '0, '0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("skfl_valid", 64'(bus.out_valid_o), 64'd0);
    check("skfl_ready", 64'(bus.in_ready_o),  64'd1);
    bus.out_ready_i = 1'b1;
    drive(1'b1, 16'h000B, 32'hBB, 2'b00);
    tick();
    check("skfl_next", 64'(bus.out_ctrl_o), 64'hB);
    drive(1'b0, '0, '0, '0);
    tick();
    check("skfl_nodup", 64'(bus.out_valid_o), 64'd0);
`endif

    // Bubble counter: clear, saturation at 15, clear beats increment.
    drive(1'b0, '0, '0, '0);
    bus.out_ready_i = 1'b1;
    cnt_clr_i = 1'b1;
    tick();
    check("clr_cnt", 64'(bubble_cnt_o), 64'd0);
    cnt_clr_i = 1'b0;
    bubble_i  = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("cnt_15", 64'(bubble_cnt_o), 64'd15);
    for (int i = 0; i < 4; i++) tick();
    check("cnt_sat", 64'(bubble_cnt_o), 64'd15);
    cnt_clr_i = 1'b1;
    tick();
    check("clr_wins", 64'(bubble_cnt_o), 64'd0);
    cnt_clr_i = 1'b0;
    tick();
    check("cnt_one", 64'(bubble_cnt_o), 64'd1);
    flush_i = 1'b1;
    tick();
    check("fl_bub_nocnt", 64'(bubble_cnt_o), 64'd1);
    flush_i  = 1'b0;
    bubble_i = 1'b0;

    // Asynchronous reset mid-stream.
    drive(1'b1, 16'h000C, 32'hCC, 2'b01);
    tick();
    check("pre_rst_valid", 64'(bus.out_valid_o), 64'd1);
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid_o), 64'd0);
    check("arst_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("arst_data",  64'(bus.out_data_o),  64'd0);
    check("arst_start", 64'(bus.start_o),     64'd0);
    check("arst_cnt",   64'(bubble_cnt_o),    64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("arst_norep", 64'(bus.out_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
